// File: rtl/speed_select.sv
// Push-button speed selector: sync, debounce and edge-detect two buttons, step a 2-bit mode register.
// Optional auto-repeat while one button is held is built when SPEED_SEL_AUTOREPEAT_EN is defined.
module speed_select #(
    parameter int         DEBOUNCE_CYCLES = 270000,
    parameter logic [1:0] RESET_MODE      = 2'b00,
    parameter bit         WRAP            = 1'b0,
    parameter int         REPEAT_CYCLES   = 13500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [1:0] opsw,
    output logic       mode_changed,
    output logic       up_level,
    output logic       dn_level
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]    s1_q, s2_q;
    logic [1:0]    db_q, db_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    opsw_q, opsw_d;
    logic          mc_q, mc_d;
    logic [1:0]    press, release_ev;
    logic          step_up, step_dn;

`ifdef SPEED_SEL_AUTOREPEAT_EN
    localparam logic [23:0] RPT_LAST = 24'(REPEAT_CYCLES - 1);
    logic [23:0] rpt_q, rpt_d;
`endif

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press      = db_d & ~db_q;
        release_ev = db_q & ~db_d;
        step_up    = press[0] & ~press[1];
        step_dn    = press[1] & ~press[0];

`ifdef SPEED_SEL_AUTOREPEAT_EN
        rpt_d = '0;
        // Repeat timing restarts on any level change so the first repeat is measured from the press.
        if ((db_q[0] ^ db_q[1]) && (press == 2'b00) && (release_ev == 2'b00)) begin
            if (rpt_q == RPT_LAST) begin
                step_up = db_q[0];
                step_dn = db_q[1];
            end else begin
                rpt_d = rpt_q + 24'd1;
            end
        end
`endif

        opsw_d = opsw_q;
        if (step_up) begin
            if (WRAP || (opsw_q != 2'b11)) begin
                opsw_d = opsw_q + 2'b01;
            end
        end else if (step_dn) begin
            if (WRAP || (opsw_q != 2'b00)) begin
                opsw_d = opsw_q - 2'b01;
            end
        end
        mc_d = (opsw_d != opsw_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q   <= 2'b00;
            s2_q   <= 2'b00;
            db_q   <= 2'b00;
            cnt_q  <= '{default: '0};
            opsw_q <= RESET_MODE;
            mc_q   <= 1'b0;
        end else begin
            s1_q   <= {btn_dn, btn_up};
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            opsw_q <= opsw_d;
            mc_q   <= mc_d;
        end
    end

`ifdef SPEED_SEL_AUTOREPEAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign opsw         = opsw_q;
    assign mode_changed = mc_q;
    assign up_level     = db_q[0];
    assign dn_level     = db_q[1];

endmodule

// File: tb/tb_speed_select.sv
// Bench for speed_select: directed test-plan steps then random button traffic, every cycle checked
// against a window-based behavioural model; two instances cover saturate and wrap modes.
module tb_speed_select;

    localparam int D = 4;
    localparam int R = 8;

    logic       CLK, RST, btn_up, btn_dn;
    logic [1:0] opsw_s, opsw_w;
    logic       mc_s, mc_w, upl_s, upl_w, dnl_s, dnl_w;

    speed_select #(.DEBOUNCE_CYCLES(D), .RESET_MODE(2'b10), .WRAP(1'b0), .REPEAT_CYCLES(R)) u_sat (
        .CLK(CLK), .RST(RST), .btn_up(btn_up), .btn_dn(btn_dn),
        .opsw(opsw_s), .mode_changed(mc_s), .up_level(upl_s), .dn_level(dnl_s));

    speed_select #(.DEBOUNCE_CYCLES(D), .RESET_MODE(2'b10), .WRAP(1'b1), .REPEAT_CYCLES(R)) u_wrap (
        .CLK(CLK), .RST(RST), .btn_up(btn_up), .btn_dn(btn_dn),
        .opsw(opsw_w), .mode_changed(mc_w), .up_level(upl_w), .dn_level(dnl_w));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int ps = 0, pw = 0;

    // Model state: synchroniser delay line, window of last D samples, accepted levels, modes.
    bit   m_s1 [2];
    bit   m_s2 [2];
    bit   win  [2][D];
    int   nsamp [2];
    bit   lv   [2];
    int   mop  [2];
    bit   mmc  [2];
    int   age;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit u, input bit d, input bit r);
        bit raw [2];
        bit nlv [2];
        bit pr  [2];
        bit rl  [2];
        bit all_diff;
        int delta;
        int n;
        raw[0] = u;
        raw[1] = d;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; nsamp[b] = 0; lv[b] = 0;
                mop[b] = 2; mmc[b] = 0;
            end
            age = 0;
            return;
        end
        for (int b = 0; b < 2; b++) begin
            for (int k = D - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = m_s2[b];
            if (nsamp[b] < D) nsamp[b]++;
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
            all_diff = (nsamp[b] >= D);
            for (int k = 0; k < D; k++) if (win[b][k] == lv[b]) all_diff = 0;
            nlv[b] = all_diff ? !lv[b] : lv[b];
            if (all_diff) nsamp[b] = 0;
            pr[b] = all_diff && nlv[b];
            rl[b] = all_diff && !nlv[b];
        end
        delta = int'(pr[0]) - int'(pr[1]);
`ifdef SPEED_SEL_AUTOREPEAT_EN
        if ((lv[0] != lv[1]) && !pr[0] && !pr[1] && !rl[0] && !rl[1]) begin
            age++;
            if (age == R) begin
                delta = lv[0] ? 1 : -1;
                age = 0;
            end
        end else begin
            age = 0;
        end
`endif
        lv[0] = nlv[0];
        lv[1] = nlv[1];
        for (int k = 0; k < 2; k++) begin
            n = mop[k] + delta;
            if (k == 1) n = (n + 4) % 4;
            else if (n > 3) n = 3;
            else if (n < 0) n = 0;
            mmc[k] = (n != mop[k]);
            mop[k] = n;
        end
    endtask

    task automatic tick(input bit u, input bit d, input bit r);
        btn_up = u;
        btn_dn = d;
        RST    = r;
        @(posedge CLK);
        model_edge(u, d, r);
        #1;
        chk("sat_opsw", {2'b00, opsw_s}, 4'(mop[0]));
        chk("sat_mc",   {3'b000, mc_s},  {3'b000, mmc[0]});
        chk("wrap_opsw", {2'b00, opsw_w}, 4'(mop[1]));
        chk("wrap_mc",  {3'b000, mc_w},  {3'b000, mmc[1]});
        chk("up_level", {3'b000, upl_s}, {3'b000, lv[0]});
        chk("dn_level", {3'b000, dnl_s}, {3'b000, lv[1]});
        chk("wrap_up_level", {3'b000, upl_w}, {3'b000, lv[0]});
        chk("wrap_dn_level", {3'b000, dnl_w}, {3'b000, lv[1]});
        ps += int'(mc_s);
        pw += int'(mc_w);
    endtask

    task automatic press(input bit u, input bit d);
        repeat (6) tick(u, d, 0);
        repeat (8) tick(0, 0, 0);
    endtask

    initial begin
        btn_up = 0;
        btn_dn = 0;
        RST    = 1;

        repeat (3) tick(0, 0, 1);
        chk("rst_opsw", {2'b00, opsw_s}, 4'h2);
        chk("rst_mc",   {3'b000, mc_s}, 4'h0);
        chk("rst_up",   {3'b000, upl_s}, 4'h0);
        chk("rst_dn",   {3'b000, dnl_s}, 4'h0);

        repeat (2) tick(0, 0, 0);
        press(0, 1);
        press(0, 1);
        chk("to_00", {2'b00, opsw_s}, 4'h0);

        // Held up button: press accepted at edge D+2 exactly.
        for (int e = 1; e <= 9; e++) begin
            tick(1, 0, 0);
            if (e == 5) chk("lat_e5_opsw", {2'b00, opsw_s}, 4'h0);
            if (e == 6) begin
                chk("lat_e6_opsw", {2'b00, opsw_s}, 4'h1);
                chk("lat_e6_mc",   {3'b000, mc_s}, 4'h1);
                chk("lat_e6_up",   {3'b000, upl_s}, 4'h1);
            end
            if (e == 7) chk("lat_e7_mc", {3'b000, mc_s}, 4'h0);
            if (e == 9) chk("lat_hold_opsw", {2'b00, opsw_s}, 4'h1);
        end
        repeat (8) tick(0, 0, 0);

        // Glitch rejection.
        ps = 0;
        repeat (3) tick(1, 0, 0);
        tick(0, 0, 0);
        repeat (3) tick(1, 0, 0);
        repeat (8) tick(0, 0, 0);
        chk("glitch_opsw", {2'b00, opsw_s}, 4'h1);
        chk("glitch_pulses", 4'(ps), 4'h0);

        // Saturation and wrap boundaries.
        press(1, 0);
        press(1, 0);
        chk("sat_top", {2'b00, opsw_s}, 4'h3);
        chk("wrap_top", {2'b00, opsw_w}, 4'h3);
        ps = 0; pw = 0;
        press(1, 0);
        chk("wrap_11_to_00", {2'b00, opsw_w}, 4'h0);
        chk("wrap_11_pulse", 4'(pw), 4'h1);
        press(1, 0);
        chk("sat_hold_11", {2'b00, opsw_s}, 4'h3);
        chk("sat_no_pulse", 4'(ps), 4'h0);
        ps = 0; pw = 0;
        repeat (4) press(0, 1);
        chk("sat_bottom", {2'b00, opsw_s}, 4'h0);
        chk("sat_dn_pulses", 4'(ps), 4'h3);
        chk("wrap_dn_pulses", 4'(pw), 4'h4);

        // Simultaneous presses cancel.
        ps = 0;
        for (int e = 1; e <= 6; e++) begin
            tick(1, 1, 0);
            if (e == 6) begin
                chk("both_up_level", {3'b000, upl_s}, 4'h1);
                chk("both_dn_level", {3'b000, dnl_s}, 4'h1);
            end
        end
        repeat (8) tick(0, 0, 0);
        chk("both_opsw", {2'b00, opsw_s}, 4'h0);
        chk("both_pulses", 4'(ps), 4'h0);

        // Reset mid-debounce then re-debounce of the held button.
        repeat (4) tick(1, 0, 0);
        tick(1, 0, 1);
        chk("midrst_opsw", {2'b00, opsw_s}, 4'h2);
        for (int e = 1; e <= 6; e++) begin
            tick(1, 0, 0);
            if (e == 5) chk("midrst_e5", {2'b00, opsw_s}, 4'h2);
            if (e == 6) chk("midrst_e6", {2'b00, opsw_s}, 4'h3);
        end
        repeat (8) tick(0, 0, 0);

        // Long hold of down from 11.
        pw = 0;
        for (int e = 1; e <= 30; e++) begin
            tick(0, 1, 0);
            if (e == 6) chk("hold_e6", {2'b00, opsw_w}, 4'h2);
`ifdef SPEED_SEL_AUTOREPEAT_EN
            if (e == 14) chk("rpt_e14", {2'b00, opsw_w}, 4'h1);
            if (e == 22) chk("rpt_e22", {2'b00, opsw_w}, 4'h0);
            if (e == 30) chk("rpt_e30", {2'b00, opsw_w}, 4'h3);
`else
            if (e == 30) chk("norpt_e30", {2'b00, opsw_w}, 4'h2);
`endif
        end
`ifdef SPEED_SEL_AUTOREPEAT_EN
        chk("rpt_pulses", 4'(pw), 4'h4);
`else
        chk("norpt_pulses", 4'(pw), 4'h1);
`endif
        repeat (8) tick(0, 0, 0);

        // Random button traffic with occasional reset.
        for (int s = 0; s < 80; s++) begin
            bit u, d;
            int len;
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            if ($urandom_range(0, 29) == 0) tick(u, d, 1);
            repeat (len) tick(u, d, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
